tempsens_meas_sequencer: RTL and testbench
==========================================

Name: tempsens_meas_sequencer

Overview:
Measurement controller for the delay-based on-chip temperature sensor. It sequences each conversion: precharge, start, then count clock cycles until the sensor's done edge. It averages 2^AVG_LOG2 conversions and subtracts a serially loaded calibration offset. It sits between the sensor macro and the display/debug mux, and owns the CAL_CLK/CAL_DAT/CAL_ENA calibration interface.

Parameters:
CNT_W, 12, width of the conversion counter and of the result
CAL_W, 6, width of the calibration offset shift register
AVG_LOG2, 2, log2 of the number of conversions averaged per result
SETTLE_CYC, 16, minimum number of precharge cycles before each conversion (must be ≥1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
run  in  1  level; while high, measurements repeat back-to-back
cal_clk  in  1  async serial calibration clock; 2-FF synchronised, rising-edge detected
cal_dat  in  1  serial calibration data, sampled on the detected cal_clk rising edge
cal_ena  in  1  1 = subtract offset from result; 0 = raw average
tdc_done  in  1  async sensor completion flag; 2-FF synchronised to tdc_done_s
sensor_en  out  1  sensor bias enable; high in every state except IDLE
tdc_start  out  1  conversion start; high only in CONVERT
result  out  CNT_W  last calibrated average
result_valid  out  1  one-cycle pulse when result updates
timeout  out  1  set if any sample of the current average timed out; updated with result
busy  out  1  high whenever state != IDLE
dbg_state  out  3  current state encoding

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. Counter, accumulator, sample index, offset register, synchronisers and timeout tracker cleared.
- States and encodings: IDLE=0, PRECHARGE=1, CONVERT=2, ACCUM=3, RESULT=4.
- IDLE: if run=1, go to PRECHARGE next cycle. Clear the settle counter.
- PRECHARGE: settle counter increments every cycle. Go to CONVERT once settle ≥ SETTLE_CYC-1 AND tdc_done_s=0. The phase stretches indefinitely while tdc_done_s is stuck high.
- CONVERT:
  - Counter cleared on entry. It increments each cycle while tdc_done_s=0.
  - Go to ACCUM when tdc_done_s=1, or when the counter reaches 2^CNT_W-1. The latter is a timeout: the sample is the all-ones value and the sticky timeout tracker is set.
  - Count includes the 2-cycle synchroniser latency: done asserted D cycles after tdc_start rises gives sample D+2.
- ACCUM (1 cycle):
  - acc (CNT_W+AVG_LOG2 bits) += sample; index++.
  - If index wraps to 0 (2^AVG_LOG2 samples taken), go to RESULT; otherwise go to PRECHARGE (settle counter cleared).
- RESULT (1 cycle):
  - avg = acc >> AVG_LOG2 (truncating).
  - off = zero-extended offset if cal_ena=1, else 0.
  - result <= (avg ≥ off) ? avg-off : 0. No underflow wrap.
  - timeout output <= tracker; result_valid=1; then clear acc, index and tracker.
  - Next state: PRECHARGE if run=1, else IDLE.
- run deasserted mid-average: the current average completes and is reported, then IDLE.
- Calibration shift:
  - On each synchronised cal_clk rising edge: offset <= {offset[CAL_W-2:0], cal_dat_s}, MSB first. This runs in any state.
  - cal_dat is sampled through the same 2-FF delay as cal_clk.
  - A shift during a measurement affects only RESULTs computed after it.
- cal_ena is sampled in RESULT only.
- result holds its value between updates.

Decomposition:
- Shared package tempsens_pkg holds:
  - state enum/localparams (IDLE..RESULT);
  - default widths CNT_W/CAL_W;
  - SYNC_STAGES=2.
- One natural sub-module: tempsens_sync2 (2-FF synchroniser with async reset), instantiated for tdc_done, cal_clk and cal_dat.
- Edge detection and FSM stay in the top.

Test Plan:
All tests use CNT_W=12, CAL_W=6, AVG_LOG2=2, SETTLE_CYC=4.
1. Hold RESET 3 cycles with run=1, cal_clk toggling -> all outputs 0, dbg_state=0, no shift recorded. Release -> PRECHARGE 1 cycle later.
2. cal_ena=0, sensor model asserts tdc_done 98 cycles after tdc_start rise and drops it when tdc_start falls -> 4 conversions; result=100, result_valid pulses once, timeout=0.
3. Model delays 98,99,100,101 (samples 100..103, acc=406) -> result=101.
4. Shift 6'b001010 MSB-first via cal_clk (value 10), cal_ena=1, samples 100 -> result=90. Then shift 6'b111111 (63) with samples 50 -> result=0.
5. tdc_done never asserted, cal_ena=0 -> each CONVERT lasts 4095 counts; result=4095, timeout=1. The next normal average clears timeout to 0.
6. Assert RESET mid-CONVERT of sample 2 -> tdc_start and sensor_en drop asynchronously. After release with run=1, a full fresh 4-sample average is reported (result=100 with model delay 98).

Source files
------------

// File: rtl/tempsens_pkg.sv
// Shared state encoding and default widths for the temperature-sensor
// measurement sequencer and its synchronisers.
package tempsens_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_CONVERT   = 3'd2,
    ST_ACCUM     = 3'd3,
    ST_RESULT    = 3'd4
  } state_t;

  localparam int CNT_W_DEF   = 12;
  localparam int CAL_W_DEF   = 6;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/tempsens_sync2.sv
// Multi-flop synchroniser for asynchronous single-bit inputs (sensor done
// flag and the serial calibration lines).
module tempsens_sync2
  import tempsens_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/tempsens_meas_sequencer.sv
// Conversion sequencer for the delay-based temperature sensor: precharge,
// start, count to done, average 2^AVG_LOG2 samples, subtract calibration.
//
// state      | meaning
// IDLE       | sensor biased off, waiting for run
// PRECHARGE  | settle period; waits for the done flag to be low
// CONVERT    | tdc_start high, counting cycles until done or timeout
// ACCUM      | add the captured sample, advance sample index
// RESULT     | publish calibrated average and sticky timeout
module tempsens_meas_sequencer
  import tempsens_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int CAL_W      = CAL_W_DEF,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             cal_clk,
  input  logic             cal_dat,
  input  logic             cal_ena,
  input  logic             tdc_done,
  output logic             sensor_en,
  output logic             tdc_start,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             timeout,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int SET_W = $clog2(SETTLE_CYC) + 1;
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t              state;
  logic [SET_W-1:0]    settle;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    sample;
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] idx;
  logic                to_track;
  logic [CAL_W-1:0]    offset;
  logic                done_s;
  logic                cal_clk_s;
  logic                cal_dat_s;
  logic                cal_clk_q;
  logic [CNT_W-1:0]    avg;
  logic [CNT_W-1:0]    off;

  tempsens_sync2 u_sync_done (.clk(CLK), .rst(RESET), .d(tdc_done), .q(done_s));
  tempsens_sync2 u_sync_cclk (.clk(CLK), .rst(RESET), .d(cal_clk),  .q(cal_clk_s));
  tempsens_sync2 u_sync_cdat (.clk(CLK), .rst(RESET), .d(cal_dat),  .q(cal_dat_s));

  // Calibration shifter runs independently of the measurement FSM.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cal_clk_q <= 1'b0;
      offset    <= '0;
    end else begin
      cal_clk_q <= cal_clk_s;
      if (cal_clk_s && !cal_clk_q) offset <= {offset[CAL_W-2:0], cal_dat_s};
    end
  end

  assign avg       = CNT_W'(acc >> AVG_LOG2);
  assign off       = cal_ena ? CNT_W'(offset) : '0;
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      settle       <= '0;
      cnt          <= '0;
      sample       <= '0;
      acc          <= '0;
      idx          <= '0;
      to_track     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      sensor_en    <= 1'b0;
      tdc_start    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          settle <= '0;
          if (run) begin
            state     <= ST_PRECHARGE;
            sensor_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_PRECHARGE: begin
          // A stuck-high done flag stretches precharge until it clears.
          if (settle >= SETTLE_LAST && !done_s) begin
            state     <= ST_CONVERT;
            tdc_start <= 1'b1;
            cnt       <= '0;
          end else if (settle < SETTLE_LAST) begin
            settle <= settle + 1'b1;
          end
        end
        ST_CONVERT: begin
          if (done_s || cnt == CNT_MAX) begin
            state     <= ST_ACCUM;
            tdc_start <= 1'b0;
            sample    <= cnt;
            if (!done_s) to_track <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACCUM: begin
          acc    <= acc + ACC_W'(sample);
          idx    <= idx + 1'b1;
          settle <= '0;
          state  <= (&idx) ? ST_RESULT : ST_PRECHARGE;
        end
        ST_RESULT: begin
          result       <= (avg >= off) ? (avg - off) : '0;
          timeout      <= to_track;
          result_valid <= 1'b1;
          acc          <= '0;
          idx          <= '0;
          to_track     <= 1'b0;
          settle       <= '0;
          if (run) begin
            state <= ST_PRECHARGE;
          end else begin
            state     <= ST_IDLE;
            sensor_en <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          sensor_en <= 1'b0;
          tdc_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tempsens_meas_sequencer.sv
// Directed bench for the temperature-sensor sequencer: vector table of
// per-average sensor delays and calibration, plus reset corner sequences.
module tb_tempsens_meas_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        run = 1'b1;
  logic        cal_clk = 1'b0;
  logic        cal_dat = 1'b1;
  logic        cal_ena = 1'b0;
  logic        tdc_done = 1'b0;
  logic        sensor_en, tdc_start, result_valid, timeout, busy;
  logic [11:0] result;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  tempsens_meas_sequencer #(
    .CNT_W(12), .CAL_W(6), .AVG_LOG2(2), .SETTLE_CYC(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .run(run), .cal_clk(cal_clk), .cal_dat(cal_dat),
    .cal_ena(cal_ena), .tdc_done(tdc_done), .sensor_en(sensor_en),
    .tdc_start(tdc_start), .result(result), .result_valid(result_valid),
    .timeout(timeout), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Sensor model: done rises delays[k] cycles after tdc_start rises (-1 = never),
  // and falls once tdc_start falls.
  int delays [4] = '{98, 98, 98, 98};
  int conv_idx = 0;
  int k = 0;
  bit active = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (RESET) begin
      conv_idx = 0;
      active   = 1'b0;
      tdc_done = 1'b0;
    end else if (tdc_start && !active) begin
      active = 1'b1;
      k      = 0;
    end else if (active && !tdc_start) begin
      active   = 1'b0;
      tdc_done = 1'b0;
      conv_idx = (conv_idx + 1) % 4;
    end else if (active) begin
      k++;
      if (delays[conv_idx] >= 0 && k == delays[conv_idx]) tdc_done = 1'b1;
    end
  end

  typedef struct {
    int          d0, d1, d2, d3;
    bit          ena;
    bit          do_shift;
    logic [5:0]  shift_val;
    logic [11:0] exp_result;
    bit          exp_timeout;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!result_valid && n < budget);
    if (!result_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no result_valid after %0d cycles", n);
    end
  endtask

  task automatic shift_cal(input logic [5:0] v);
    for (int b = 5; b >= 0; b--) begin
      cal_dat = v[b];
      repeat (3) @(posedge CLK);
      #1 cal_clk = 1'b1;
      repeat (4) @(posedge CLK);
      #1 cal_clk = 1'b0;
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    vec[0]  = '{98, 98, 98, 98,   1'b0, 1'b0, 6'd0,  12'd100,  1'b0};
    vec[1]  = '{98, 98, 98, 98,   1'b1, 1'b0, 6'd0,  12'd100,  1'b0};
    vec[2]  = '{98, 99, 100, 101, 1'b0, 1'b0, 6'd0,  12'd101,  1'b0};
    vec[3]  = '{98, 98, 98, 98,   1'b1, 1'b1, 6'd10, 12'd90,   1'b0};
    vec[4]  = '{48, 48, 48, 48,   1'b1, 1'b1, 6'd63, 12'd0,    1'b0};
    vec[5]  = '{61, 61, 61, 61,   1'b1, 1'b0, 6'd0,  12'd0,    1'b0};
    vec[6]  = '{62, 62, 62, 62,   1'b1, 1'b0, 6'd0,  12'd1,    1'b0};
    vec[7]  = '{98, 98, 98, 98,   1'b0, 1'b0, 6'd0,  12'd100,  1'b0};
    vec[8]  = '{-1, -1, -1, -1,   1'b0, 1'b0, 6'd0,  12'd4095, 1'b1};
    vec[9]  = '{98, 98, 98, 98,   1'b0, 1'b0, 6'd0,  12'd100,  1'b0};
    vec[10] = '{98, -1, 98, 98,   1'b0, 1'b0, 6'd0,  12'd1098, 1'b1};
    vec[11] = '{98, 98, 98, 98,   1'b1, 1'b0, 6'd0,  12'd37,   1'b0};

    // Reset held with run high and cal_clk toggling (cal_dat=1 would show a shift).
    repeat (3) begin
      @(posedge CLK); #1 cal_clk = ~cal_clk;
    end
    cal_clk = 1'b0;
    chk("rst_sensor_en", sensor_en, 0);
    chk("rst_tdc_start", tdc_start, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge CLK); #1;
    RESET   = 1'b0;
    cal_dat = 1'b0;
    @(posedge CLK); #1;
    chk("rel_state", dbg_state, 1);
    chk("rel_sensor_en", sensor_en, 1);
    chk("rel_busy", busy, 1);
    n = 0;
    while (!tdc_start && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("precharge_len", n, 4);
    chk("convert_state", dbg_state, 2);

    for (int i = 0; i < NV; i++) begin
      delays[0] = vec[i].d0;
      delays[1] = vec[i].d1;
      delays[2] = vec[i].d2;
      delays[3] = vec[i].d3;
      cal_ena   = vec[i].ena;
      if (vec[i].do_shift) shift_cal(vec[i].shift_val);
      wait_valid(20000, n);
      chk($sformatf("v%0d_result", i), result, vec[i].exp_result);
      chk($sformatf("v%0d_timeout", i), timeout, vec[i].exp_timeout);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_valid_pulse", i), result_valid, 0);
      chk($sformatf("v%0d_result_hold", i), result, vec[i].exp_result);
    end

    // Reset during the third conversion, then a full fresh average.
    delays  = '{98, 98, 98, 98};
    cal_ena = 1'b0;
    n = 0;
    while (!(tdc_start && conv_idx == 2) && n < 2000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("reach_sample2", (tdc_start && conv_idx == 2), 1);
    repeat (20) @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    chk("async_tdc_start", tdc_start, 0);
    chk("async_sensor_en", sensor_en, 0);
    chk("async_state", dbg_state, 0);
    chk("async_result", result, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    wait_valid(5000, n);
    chk("fresh_avg_len", (n > 400 && n < 500), 1);
    chk("fresh_result", result, 100);
    chk("fresh_timeout", timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
